// File: rtl/capi_pargen_pipe.sv
// Transmit-side odd-parity generator for CAPI links: two-entry skid pipeline,
// one-shot parity error injection on p[0] and a saturating transfer counter.
module capi_pargen_pipe #(
  parameter int width  = 64,
  parameter int pwidth = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_v,
  output logic              i_r,
  input  logic [0:width-1]  i_d,
  output logic              o_v,
  input  logic              o_r,
  output logic [0:width-1]  o_d,
  output logic [0:pwidth-1] o_p,
  input  logic              i_inj,
  output logic              o_inj_done,
  output logic [15:0]       o_cnt
);

  // width must be a multiple of pwidth; each parity bit covers seg contiguous bits
  localparam int seg = width / pwidth;

  function automatic logic [0:pwidth-1] odd_parity(input logic [0:width-1] d);
    logic [0:pwidth-1] p;
    p = {pwidth{1'b0}};
    for (int k = 0; k < pwidth; k++) begin
      p[k] = ~^d[k*seg +: seg];
    end
    return p;
  endfunction

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;

  logic              main_v_r;
  logic [0:width-1]  main_d_r;
  logic [0:pwidth-1] main_p_r;
  logic              skid_v_r;
  logic [0:width-1]  skid_d_r;
  logic [0:pwidth-1] skid_p_r;
  logic              i_r_r;
  logic              armed_r;
  logic              inj_done_r;
  logic [15:0]       cnt_r;

  logic              accept_s;
  logic              xfer_s;
  logic [0:pwidth-1] in_p_s;
  logic              main_v_s;
  logic              skid_v_s;
  logic              main_ld_in_s;
  logic              main_ld_skid_s;
  logic              skid_ld_s;
  logic              armed_s;
  logic [15:0]       cnt_s;

  // Reset synchronizer: assertion passes straight through, release waits two edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Handshake decode, parity generation and next-state for entries, flag and counter
  always_comb begin
    accept_s       = i_v & i_r_r;
    xfer_s         = main_v_r & o_r;
    in_p_s         = odd_parity(i_d);
    in_p_s[0]      = in_p_s[0] ^ armed_r;
    main_v_s       = main_v_r;
    skid_v_s       = skid_v_r;
    main_ld_in_s   = 1'b0;
    main_ld_skid_s = 1'b0;
    skid_ld_s      = 1'b0;

    // accept cannot coincide with skid valid because i_r is low then
    if (xfer_s && skid_v_r) begin
      main_ld_skid_s = 1'b1;
      skid_v_s       = 1'b0;
    end else if (accept_s && (!main_v_r || xfer_s)) begin
      main_ld_in_s = 1'b1;
      main_v_s     = 1'b1;
    end else if (accept_s) begin
      skid_ld_s = 1'b1;
      skid_v_s  = 1'b1;
    end else if (xfer_s) begin
      main_v_s = 1'b0;
    end else begin
      main_v_s = main_v_r;
    end

    // a new request wins over consumption so it re-arms for a later beat
    if (i_inj) begin
      armed_s = 1'b1;
    end else if (accept_s) begin
      armed_s = 1'b0;
    end else begin
      armed_s = armed_r;
    end

    if (xfer_s && (cnt_r != 16'hFFFF)) begin
      cnt_s = cnt_r + 16'd1;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Control state: entry valids, ready flag, injection flag, done pulse, counter
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      main_v_r   <= 1'b0;
      skid_v_r   <= 1'b0;
      i_r_r      <= 1'b1;
      armed_r    <= 1'b0;
      inj_done_r <= 1'b0;
      cnt_r      <= 16'd0;
    end else begin
      main_v_r   <= main_v_s;
      skid_v_r   <= skid_v_s;
      i_r_r      <= ~skid_v_s;
      armed_r    <= armed_s;
      inj_done_r <= accept_s & armed_r;
      cnt_r      <= cnt_s;
    end
  end

  // Data/parity storage; main holds its contents while stalled or empty
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      main_d_r <= {width{1'b0}};
      main_p_r <= {pwidth{1'b0}};
      skid_d_r <= {width{1'b0}};
      skid_p_r <= {pwidth{1'b0}};
    end else begin
      if (main_ld_in_s) begin
        main_d_r <= i_d;
        main_p_r <= in_p_s;
      end else if (main_ld_skid_s) begin
        main_d_r <= skid_d_r;
        main_p_r <= skid_p_r;
      end else begin
        main_d_r <= main_d_r;
        main_p_r <= main_p_r;
      end
      if (skid_ld_s) begin
        skid_d_r <= i_d;
        skid_p_r <= in_p_s;
      end else begin
        skid_d_r <= skid_d_r;
        skid_p_r <= skid_p_r;
      end
    end
  end

  assign i_r        = i_r_r;
  assign o_v        = main_v_r;
  assign o_d        = main_d_r;
  assign o_p        = main_p_r;
  assign o_inj_done = inj_done_r;
  assign o_cnt      = cnt_r;

endmodule

// File: tb/tb_capi_pargen_pipe.sv
// Directed self-checking bench for capi_pargen_pipe at width 16, pwidth 2.
module tb_capi_pargen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_v;
  logic        i_r;
  logic [0:15] i_d;
  logic        o_v;
  logic        o_r;
  logic [0:15] o_d;
  logic [0:1]  o_p;
  logic        i_inj;
  logic        o_inj_done;
  logic [15:0] o_cnt;

  int checks = 0;
  int errors = 0;

  capi_pargen_pipe #(.width(16), .pwidth(2)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_p(o_p),
    .i_inj(i_inj), .o_inj_done(o_inj_done), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  // Upper byte is segment 0 (o_p[0], the left bit); odd parity means set when the count is even
  function automatic logic [1:0] exp_par(input logic [15:0] d);
    logic [1:0] p;
    p[1] = ($countones(d[15:8]) % 2 == 0);
    p[0] = ($countones(d[7:0]) % 2 == 0);
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b0; i_v = 1'b0; i_inj = 1'b0; o_r = 1'b0; i_d = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL reset_o_v got %0b exp 0", o_v); end
    checks++; if (i_r !== 1'b1) begin errors++; $display("FAIL reset_i_r got %0b exp 1", i_r); end
    checks++; if (o_cnt !== 16'd0) begin errors++; $display("FAIL reset_o_cnt got %0d exp 0", o_cnt); end
    checks++; if (o_inj_done !== 1'b0) begin errors++; $display("FAIL reset_inj_done got %0b exp 0", o_inj_done); end
    checks++; if (o_d !== 16'h0000 || o_p !== 2'b00) begin
      errors++; $display("FAIL reset_data got d=%h p=%b exp d=0000 p=00", o_d, o_p);
    end
  endtask

  task automatic test_parity();
    logic [15:0] vec [3];
    logic [1:0]  pex [3];
    vec[0] = 16'h0001; pex[0] = 2'b10;
    vec[1] = 16'hFFFF; pex[1] = 2'b11;
    vec[2] = 16'h0300; pex[2] = 2'b11;
    do_reset();
    o_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_v = 1'b1; i_d = vec[i];
      @(negedge clk);
      i_v = 1'b0;
      checks++; if (o_v !== 1'b1 || o_d !== vec[i] || o_p !== pex[i]) begin
        errors++; $display("FAIL parity_%0d got v=%0b d=%h p=%b exp v=1 d=%h p=%b", i, o_v, o_d, o_p, vec[i], pex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    do_reset();
    o_r = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_d = 16'h1230 + 16'(i - 1);
        checks++; if (o_v !== 1'b1 || o_d !== exp_d || o_p !== exp_par(exp_d)) begin
          errors++; $display("FAIL stream_beat_%0d got v=%0b d=%h p=%b exp v=1 d=%h p=%b", i - 1, o_v, o_d, o_p, exp_d, exp_par(exp_d));
        end
      end
      checks++; if (i_r !== 1'b1) begin errors++; $display("FAIL stream_i_r cycle %0d got %0b exp 1", i, i_r); end
      i_v = 1'b1; i_d = 16'h1230 + 16'(i);
    end
    @(negedge clk);
    exp_d = 16'h1230 + 16'd99;
    checks++; if (o_v !== 1'b1 || o_d !== exp_d) begin
      errors++; $display("FAIL stream_last got v=%0b d=%h exp v=1 d=%h", o_v, o_d, exp_d);
    end
    i_v = 1'b0;
    @(negedge clk);
    checks++; if (o_cnt !== 16'd100 || o_v !== 1'b0) begin
      errors++; $display("FAIL stream_cnt got cnt=%0d v=%0b exp cnt=100 v=0", o_cnt, o_v);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] sb [$];
    int sent = 0;
    int got = 0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 6) begin
        checks++; if (i_r !== 1'b0 || o_d !== 16'hA004) begin
          errors++; $display("FAIL bp_c6 got i_r=%0b d=%h exp i_r=0 d=a004", i_r, o_d);
        end
      end
      if (c == 7 || c == 10) begin
        checks++; if (o_v !== 1'b1 || i_r !== 1'b0) begin
          errors++; $display("FAIL bp_full_c%0d got v=%0b i_r=%0b exp v=1 i_r=0", c, o_v, i_r);
        end
      end
      if (c == 11) begin
        checks++; if (i_r !== 1'b1 || o_d !== 16'hA005) begin
          errors++; $display("FAIL bp_resume got i_r=%0b d=%h exp i_r=1 d=a005", i_r, o_d);
        end
      end
      o_r = !(c >= 5 && c <= 9);
      i_v = (c < 16);
      i_d = 16'hA000 + 16'(sent);
      if (o_v && o_r) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_order got d=%h exp no beat", o_d);
        end else begin
          if (o_d !== sb[0] || o_p !== exp_par(sb[0])) begin
            errors++; $display("FAIL bp_order got d=%h p=%b exp d=%h p=%b", o_d, o_p, sb[0], exp_par(sb[0]));
          end
          void'(sb.pop_front());
        end
        got++;
      end
      if (i_v && i_r) begin
        sb.push_back(i_d);
        sent++;
      end
    end
    i_v = 1'b0;
    @(negedge clk);
    checks++; if (sent != 11 || got != 11 || sb.size() != 0) begin
      errors++; $display("FAIL bp_counts got sent=%0d out=%0d left=%0d exp 11 11 0", sent, got, sb.size());
    end
    checks++; if (o_cnt !== 16'd11) begin errors++; $display("FAIL bp_cnt got %0d exp 11", o_cnt); end
  endtask

  task automatic test_injection();
    logic [0:11] inj_seq;
    logic [0:11] v_seq;
    logic [0:11] done_seq;
    inj_seq  = 12'b1001_1001_1000;
    v_seq    = 12'b0111_0110_1110;
    done_seq = 12'b0100_0100_1100;
    do_reset();
    o_r = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (o_v !== v_seq[i-1] || o_inj_done !== done_seq[i-1]) begin
          errors++; $display("FAIL inj_step_%0d got v=%0b done=%0b exp v=%0b done=%0b", i - 1, o_v, o_inj_done, v_seq[i-1], done_seq[i-1]);
        end
        if (v_seq[i-1]) begin
          checks++; if (o_d !== 16'h0001 || o_p !== (done_seq[i-1] ? 2'b00 : 2'b10)) begin
            errors++; $display("FAIL inj_par_%0d got d=%h p=%b exp d=0001 p=%b", i - 1, o_d, o_p, done_seq[i-1] ? 2'b00 : 2'b10);
          end
        end
      end
      if (i < 12) begin
        i_inj = inj_seq[i]; i_v = v_seq[i]; i_d = 16'h0001;
      end else begin
        i_inj = 1'b0; i_v = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); i_v = 1'b1; i_d = 16'h1111;
    @(negedge clk); i_d = 16'h2222;
    @(negedge clk); i_v = 1'b0; i_inj = 1'b1;
    @(negedge clk); i_inj = 1'b0;
    checks++; if (o_v !== 1'b1 || i_r !== 1'b0 || o_d !== 16'h1111) begin
      errors++; $display("FAIL rstmid_full got v=%0b i_r=%0b d=%h exp v=1 i_r=0 d=1111", o_v, i_r, o_d);
    end
    reset = 1'b0;
    #1;
    checks++; if (o_v !== 1'b0 || i_r !== 1'b1 || o_d !== 16'h0000 || o_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_immediate got v=%0b i_r=%0b d=%h cnt=%0d exp 0 1 0000 0", o_v, i_r, o_d, o_cnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    o_r = 1'b1; i_v = 1'b1; i_d = 16'h0001;
    @(negedge clk);
    i_v = 1'b0;
    checks++; if (o_v !== 1'b1 || o_d !== 16'h0001 || o_p !== 2'b10) begin
      errors++; $display("FAIL rstmid_clean got v=%0b d=%h p=%b exp v=1 d=0001 p=10", o_v, o_d, o_p);
    end
    @(negedge clk);
    checks++; if (o_inj_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %0b exp 0", o_inj_done); end
  endtask

  task automatic test_saturation();
    do_reset();
    o_r = 1'b1; i_d = 16'h0001;
    for (int i = 0; i < 65541; i++) begin
      @(negedge clk);
      if (i == 1001) begin
        checks++; if (o_cnt !== 16'd1000) begin errors++; $display("FAIL sat_mid got %0d exp 1000", o_cnt); end
      end
      i_v = (i < 65540);
    end
    repeat (3) @(negedge clk);
    checks++; if (o_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h exp ffff", o_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; i_v = 1'b0; i_inj = 1'b0; o_r = 1'b0; i_d = 16'h0000;
    test_reset();
    test_parity();
    test_back_to_back();
    test_backpressure();
    test_injection();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capi_pargen_pipe.md
# capi_pargen_pipe

Transmit-side parity generation stage for CAPI datapaths. It accepts data beats over a valid/ready handshake and computes odd parity per segment. Each beat is buffered in a 2-entry skid pipeline so data and parity leave together at full throughput. It also provides one-shot parity error injection and a transferred-beat counter. It is the sending end of every parity-checked link: the downstream receiver recomputes parity over `o_d` and flags a mismatch against `o_p`.

## Interface
- `width`, 64: data bits per beat.
- `pwidth`, 8: parity bits per beat. Must divide `width` exactly. Each parity bit covers `width/pwidth` contiguous data bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to `clk`).
- `i_v`  in  1  input beat valid.
- `i_r`  out  1  input ready; registered.
- `i_d`  in  [0:width-1]  input data.
- `o_v`  out  1  output beat valid.
- `o_r`  in  1  downstream ready.
- `o_d`  out  [0:width-1]  output data.
- `o_p`  out  [0:pwidth-1]  output parity; `o_p[k]` covers `o_d[k*S : k*S+S-1]`, where S = `width/pwidth`.
- `i_inj`  in  1  parity error injection request (pulse).
- `o_inj_done`  out  1  one-cycle pulse: an injected beat was accepted.
- `o_cnt`  out  16  count of beats transferred at the output, saturating.

## Operation
- Parity convention is odd: `p[k] = ~^segment_k`, so each segment plus its parity bit has an odd number of ones.
- Parity is computed combinationally from `i_d` at accept. It is stored in the same entry as the data, so `o_d` and `o_p` are never skewed.
- Storage consists of a main entry (drives the outputs) and a skid entry.
  - Accept: `i_v & i_r`.
  - Transfer: `o_v & o_o_r`, i.e. `o_v & o_r`.
  - `i_r` = the skid entry is empty (registered flag).
  - `o_v` = the main entry is valid.
- Entry updates:
  - Accept with main empty, or with main transferring and skid empty: the beat loads into main.
  - Accept while main is valid and not transferring: the beat loads into skid.
  - Transfer with skid valid: skid moves to main and skid clears.
  - Simultaneous accept and transfer with skid valid cannot occur, because `i_r` = 0 whenever skid is valid.
- Order is strictly FIFO; no beat is dropped or duplicated.
- `o_d`/`o_p` hold their value while `o_v & ~o_r`.
- Injection:
  - `i_inj` = 1 sets the `armed` flag on the next edge.
  - While armed, the next accepted beat has `p[0]` inverted before storage. `armed` clears on that edge and `o_inj_done` pulses on the following cycle.
  - `i_inj` coincident with an accept does not corrupt that beat; it arms for a later beat.
  - `i_inj` while already armed has no extra effect, so only one beat is corrupted.
  - `i_inj` coincident with the edge that consumes `armed` re-arms the flag.
- Counter: `o_cnt` increments by 1 on each transfer and saturates at 0xFFFF; it never wraps.
- Reset values: main and skid empty, `armed` = 0.
  - Outputs: `o_v` = 0, `i_r` = 1, `o_d` = 0, `o_p` = 0, `o_inj_done` = 0, `o_cnt` = 0.
  - Reset mid-operation discards all buffered beats and any pending injection.

## Timing
- Latency: a beat accepted at edge N is presented on `o_v`/`o_d`/`o_p` in cycle N+1, when main was empty or transferring at N.
- Throughput: one beat per cycle with `o_r` held at 1.
- Backpressure: `o_r` is deasserted in cycle N. Main is full and holding, so a beat accepted at N goes to skid, and `i_r` falls in cycle N+1 — a one-cycle-late ready with skid absorption.
- After `o_r` returns: the first transfer edge moves skid into main and `i_r` rises the following cycle.
- `o_inj_done`: asserted in the cycle after the corrupting accept, for exactly one cycle.
- `o_cnt` reflects a transfer at edge N in cycle N+1.

## Test plan
- Reset, then check idle outputs: `o_v` = 0, `i_r` = 1, `o_cnt` = 0, `o_inj_done` = 0.
- Parity, with width = 16, pwidth = 2 and `o_r` = 1:
  - `i_d` = 0x0001 -> next cycle `o_d` = 0x0001, `o_p` = 2'b10.
  - `i_d` = 0xFFFF -> `o_p` = 2'b11.
  - `i_d` = 0x0300 -> `o_p` = 2'b11.
- Streaming: 100 back-to-back beats with an incrementing pattern and `o_r` = 1 -> output matches in order at one beat per cycle, `i_r` never drops, `o_cnt` = 100.
- Backpressure: drop `o_r` for 5 cycles mid-stream with `i_v` held -> exactly two beats are buffered, `i_r` = 0 from the second cycle, and no loss, duplication or reordering after `o_r` returns.
- Injection: pulse `i_inj`, then send 0x0001, 0x0001 -> the first beat has `o_p` = 2'b00 and the second 2'b10. `o_inj_done` pulses once. A second `i_inj` while armed corrupts only one beat.
- Reset mid-traffic with both entries full -> `o_v` = 0 and `i_r` = 1 immediately, `armed` is cleared, and the next beat exits unmodified. Drive 65540 transfers -> `o_cnt` = 0xFFFF.
